fpdiv: RTL and testbench

- Multi-cycle IEEE 754 single-precision divider (rs1 / rs2) for the FP execution unit.
- Sits beside the pipelined adder and takes the same 32-bit operand format.
- Uses a start/done handshake and a radix-2 restoring iteration instead of a fixed pipeline.
- Rounding is truncation toward zero; subnormal inputs and outputs are flushed to signed zero.

---
 rtl/fp_pkg.sv | 44 ++++
 rtl/fpdiv_iter.sv | 66 ++++++
 rtl/fpdiv.sv | 177 +++++++++++++++++
 tb/tb_fpdiv.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared IEEE 754 single-precision constants, classification helper and fpdiv state encoding
//
// Purpose: common definitions for the FP execution unit (adder, divider, future multiplier).
// Ports:   none (package).

package fp_pkg;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;
    localparam int QBITS    = 25;

    localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_POS_INF   = 32'h7F80_0000;

    localparam logic [EXP_W-1:0] FP_EXP_ZERO = 8'h00;
    localparam logic [EXP_W-1:0] FP_EXP_MAX  = 8'hFF;

    // Operand classes; subnormals (E==0, M!=0) are treated as zero.
    localparam logic [1:0] FP_CLS_NORM = 2'd0;
    localparam logic [1:0] FP_CLS_ZERO = 2'd1;
    localparam logic [1:0] FP_CLS_INF  = 2'd2;
    localparam logic [1:0] FP_CLS_NAN  = 2'd3;

    // fpdiv FSM encoding
    localparam logic [1:0] FPDIV_IDLE = 2'd0;
    localparam logic [1:0] FPDIV_PREP = 2'd1;
    localparam logic [1:0] FPDIV_DIV  = 2'd2;
    localparam logic [1:0] FPDIV_NORM = 2'd3;

    function automatic logic [1:0] fp_classify(input logic [EXP_W-1:0] e,
                                               input logic [MAN_W-1:0] m);
        logic [1:0] cls;
        if (e == FP_EXP_ZERO) begin
            cls = FP_CLS_ZERO;
        end else if (e == FP_EXP_MAX) begin
            cls = (m == '0) ? FP_CLS_INF : FP_CLS_NAN;
        end else begin
            cls = FP_CLS_NORM;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fpdiv_iter.sv
// rtl/fpdiv_iter.sv - radix-2 restoring division datapath (remainder, quotient, step counter)
//
// Purpose: produces QBITS quotient bits of ma/mb, one bit per step, MSB first.
// Ports:   clk, reset (async, active-high)
//          load  - initialise remainder=ma, quotient=0, count=0
//          step  - perform one restoring iteration
//          ma,mb - significands with hidden bit
//          q     - quotient register
//          count - number of completed steps since load

module fpdiv_iter #(
    parameter int QBITS = 25,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [QBITS-2:0] ma,
    input  logic [QBITS-2:0] mb,
    output logic [QBITS-1:0] q,
    output logic [CNT_W-1:0] count
);

    logic [QBITS-1:0] rem_q, rem_d;
    logic [QBITS-1:0] q_q, q_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             ge;
    logic [QBITS-1:0] rem_sel;

    always_comb begin
        rem_d   = rem_q;
        q_d     = q_q;
        count_d = count_q;
        ge      = (rem_q >= {1'b0, mb});
        rem_sel = ge ? (rem_q - {1'b0, mb}) : rem_q;
        if (load) begin
            rem_d   = {1'b0, ma};
            q_d     = '0;
            count_d = '0;
        end else if (step) begin
            // After a restoring subtract the remainder is below mb < 2^(QBITS-1),
            // so the left shift never loses a set bit.
            rem_d   = rem_sel << 1;
            q_d     = {q_q[QBITS-2:0], ge};
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q   <= '0;
            q_q     <= '0;
            count_q <= '0;
        end else begin
            rem_q   <= rem_d;
            q_q     <= q_d;
            count_q <= count_d;
        end
    end

    assign q     = q_q;
    assign count = count_q;

endmodule

// File: rtl/fpdiv.sv
// rtl/fpdiv.sv - multi-cycle IEEE 754 single-precision divider (rs1 / rs2), truncating, FTZ
//
// Purpose: start/done divider for the FP execution unit; special-case handling,
//          FSM and normalisation, with the iteration datapath in fpdiv_iter.
// Ports:   clk, reset (async, active-high)
//          start   - request, sampled only in IDLE
//          rs1,rs2 - dividend / divisor, captured on accepted start
//          busy    - high whenever not IDLE
//          done    - one-cycle pulse when out updates
//          out     - quotient, held until the next done

module fpdiv #(
    parameter int EXP_BIAS = fp_pkg::EXP_BIAS,
    parameter int QBITS    = fp_pkg::QBITS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic        done,
    output logic [31:0] out
);

    import fp_pkg::*;

    localparam int              CNT_W    = $clog2(QBITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(QBITS - 1);

    logic [1:0]        state_q, state_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic              sign_q, sign_d;
    logic signed [9:0] exp_q, exp_d;
    logic              special_q, special_d;
    logic [31:0]       spec_res_q, spec_res_d;
    logic              done_q, done_d;
    logic [31:0]       out_q, out_d;

    logic [1:0]        cls_a, cls_b;
    logic              sign_ab;
    logic              iter_load, iter_step;
    logic [QBITS-1:0]  q;
    logic [CNT_W-1:0]  count;

    logic signed [9:0]  exp_n;
    logic [MAN_W-1:0]   mant_n;
    logic [31:0]        norm_res;

    assign cls_a   = fp_classify(a_q[30:23], a_q[22:0]);
    assign cls_b   = fp_classify(b_q[30:23], b_q[22:0]);
    assign sign_ab = a_q[31] ^ b_q[31];

    assign iter_load = (state_q == FPDIV_PREP);
    assign iter_step = (state_q == FPDIV_DIV);

    fpdiv_iter #(
        .QBITS (QBITS),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk   (clk),
        .reset (reset),
        .load  (iter_load),
        .step  (iter_step),
        .ma    ({1'b1, a_q[22:0]}),
        .mb    ({1'b1, b_q[22:0]}),
        .q     (q),
        .count (count)
    );

    // Normalisation: the quotient of two [1,2) significands lies in (0.5,2),
    // so at most one left shift is needed.
    always_comb begin
        if (q[QBITS-1]) begin
            mant_n = q[QBITS-2 -: MAN_W];
            exp_n  = exp_q;
        end else begin
            mant_n = q[QBITS-3 -: MAN_W];
            exp_n  = exp_q - 10'sd1;
        end
        if (special_q) begin
            norm_res = spec_res_q;
        end else if (exp_n >= 10'sd255) begin
            norm_res = {sign_q, FP_EXP_MAX, {MAN_W{1'b0}}};
        end else if (exp_n <= 10'sd0) begin
            norm_res = {sign_q, FP_EXP_ZERO, {MAN_W{1'b0}}};
        end else begin
            norm_res = {sign_q, exp_n[7:0], mant_n};
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        done_d     = 1'b0;
        out_d      = out_q;

        case (state_q)
            FPDIV_IDLE: begin
                if (start) begin
                    a_d     = rs1;
                    b_d     = rs2;
                    state_d = FPDIV_PREP;
                end
            end

            FPDIV_PREP: begin
                sign_d     = sign_ab;
                exp_d      = {2'b00, a_q[30:23]} - {2'b00, b_q[30:23]} + 10'(EXP_BIAS);
                special_d  = 1'b1;
                spec_res_d = '0;
                if (cls_a == FP_CLS_NAN || cls_b == FP_CLS_NAN) begin
                    spec_res_d = FP_CANON_NAN;
                end else if ((cls_a == FP_CLS_INF  && cls_b == FP_CLS_INF) ||
                             (cls_a == FP_CLS_ZERO && cls_b == FP_CLS_ZERO)) begin
                    spec_res_d = FP_CANON_NAN;
                end else if (cls_a == FP_CLS_INF || cls_b == FP_CLS_ZERO) begin
                    spec_res_d = {sign_ab, FP_EXP_MAX, {MAN_W{1'b0}}};
                end else if (cls_a == FP_CLS_ZERO || cls_b == FP_CLS_INF) begin
                    spec_res_d = {sign_ab, FP_EXP_ZERO, {MAN_W{1'b0}}};
                end else begin
                    special_d = 1'b0;
                end
                state_d = special_d ? FPDIV_NORM : FPDIV_DIV;
            end

            FPDIV_DIV: begin
                if (count == LAST_CNT) begin
                    state_d = FPDIV_NORM;
                end
            end

            FPDIV_NORM: begin
                out_d   = norm_res;
                done_d  = 1'b1;
                state_d = FPDIV_IDLE;
            end

            default: state_d = FPDIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FPDIV_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            done_q     <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            done_q     <= done_d;
            out_q      <= out_d;
        end
    end

    assign busy = (state_q != FPDIV_IDLE);
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_fpdiv.sv
// tb/tb_fpdiv.sv - scoreboard testbench for fpdiv with directed vectors

module tb_fpdiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] out;

    fpdiv dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .rs1   (rs1),
        .rs2   (rs2),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic prev_done = 1'b0;

    localparam int LAT_NORM = 27;
    localparam int LAT_SPEC = 2;

    always @(posedge clk) edge_cnt = edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out", out, e.val);
                    check("latency", 32'(edge_cnt - e.acc), 32'(e.lat));
                    check("busy_in_done_cycle", {31'd0, busy}, 32'd0);
                end
                if (prev_done) check("done_twice", 32'd1, 32'd0);
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // Drive start for one cycle; caller must be at a negedge.
    task automatic issue_now(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] res, input int lat);
        exp_t e;
        start = 1'b1;
        rs1   = a;
        rs2   = b;
        e.val = res;
        e.lat = lat;
        e.acc = edge_cnt + 1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat);
        @(negedge clk);
        issue_now(a, b, res, lat);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            check("timeout_waiting_done", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int lat);
        issue(a, b, res, lat);
        wait_idle();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        rs1   = '0;
        rs2   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_out",  out, 32'h0);
        reset = 1'b0;

        // Normal and special directed vectors
        run(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, LAT_NORM); // 6/2
        run(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, LAT_NORM); // 1/3 truncated
        run(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, LAT_SPEC); // -1/0
        run(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, LAT_SPEC); // 0/0
        run(32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, LAT_NORM); // overflow
        run(32'h0080_0000, 32'h4000_0000, 32'h0000_0000, LAT_NORM); // underflow flush
        run(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, LAT_SPEC); // NaN operand
        run(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, LAT_SPEC); // inf/inf
        run(32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000, LAT_SPEC); // 1/-inf
        run(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, LAT_SPEC); // -inf/2
        run(32'hC110_0000, 32'h4040_0000, 32'hC040_0000, LAT_NORM); // -9/3
        run(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, LAT_NORM); // 1/1

        // start re-asserted during cycles 5..20 must be ignored
        issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, LAT_NORM);
        repeat (4) @(negedge clk);
        start = 1'b1;
        rs1   = 32'h3F80_0000;
        rs2   = 32'h4040_0000;
        repeat (16) @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);

        // Back-to-back: new start issued in the done cycle
        issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, LAT_NORM);
        begin
            int k;
            k = 0;
            while (!done && k < 60) begin
                @(negedge clk);
                k++;
            end
            if (!done) check("b2b_first_done", 32'd0, 32'd1);
        end
        issue_now(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, LAT_NORM);
        wait_idle();

        // Reset mid-DIV
        issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, LAT_NORM);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_out",  out, 32'h0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        run(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, LAT_NORM);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
